// File: rtl/decode_stage.sv
// decode_stage: RV32I decode, 32x32 register file with write-through bypass, ID/EX register.
// Flush and reset both load an all-zero bubble; reset also clears the register file.
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } idex_t;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2;
  logic        is_lw, is_sw, is_r, is_i, is_b, is_j, wb_en;
  logic [2:0]  alu_op;
  logic [31:0] rf_q [32];
  idex_t       idex_d, idex_q;

  assign op    = InstrD[6:0];
  assign f3    = InstrD[14:12];
  assign rs1   = InstrD[19:15];
  assign rs2   = InstrD[24:20];
  assign is_lw = op == 7'b0000011;
  assign is_sw = op == 7'b0100011;
  assign is_r  = op == 7'b0110011;
  assign is_i  = op == 7'b0010011;
  assign is_b  = op == 7'b1100011;
  assign is_j  = op == 7'b1101111;
  assign wb_en = RegWriteW && RDW != 5'd0;

  always_comb begin
    alu_op = f3 == 3'b010 ? 3'b101 :
             f3 == 3'b110 ? 3'b011 :
             f3 == 3'b111 ? 3'b010 :
             (f3 == 3'b000 && is_r && InstrD[30]) ? 3'b001 : 3'b000;
    idex_d            = '0;
    idex_d.reg_write  = is_lw | is_r | is_i | is_j;
    idex_d.result_src = is_lw ? 2'b01 : is_j ? 2'b10 : 2'b00;
    idex_d.mem_write  = is_sw;
    idex_d.jump       = is_j;
    idex_d.branch     = is_b;
    idex_d.alu_src    = is_lw | is_sw | is_i;
    idex_d.alu_ctrl   = is_b ? 3'b001 : (is_r | is_i) ? alu_op : 3'b000;
    // Writeback to the register being read wins over the stored value in the same cycle
    idex_d.rd1        = rs1 == 5'd0 ? '0 : (wb_en && RDW == rs1) ? ResultW : rf_q[rs1];
    idex_d.rd2        = rs2 == 5'd0 ? '0 : (wb_en && RDW == rs2) ? ResultW : rf_q[rs2];
    idex_d.imm        = (is_lw | is_i) ? {{20{InstrD[31]}}, InstrD[31:20]} :
                        is_sw ? {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]} :
                        is_b  ? {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0} :
                        is_j  ? {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0} : '0;
    idex_d.rs1        = rs1;
    idex_d.rs2        = rs2;
    idex_d.rd         = InstrD[11:7];
    idex_d.pc         = PCD;
    idex_d.pc_plus4   = PCPlus4D;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    else if (wb_en) rf_q[RDW] <= ResultW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else idex_q <= FlushE ? '0 : idex_d;
  end

  assign {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE, ALUControlE,
          RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE, PCPlus4E} = idex_q;
endmodule
